// File: rtl/mult8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier controller: accumulates four nibble
// partial products from an external combinational 4x4 multiplier.
module mult8_seq_ctrl #(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic [3:0]  mul_m,
    output logic [3:0]  mul_q,
    input  logic [7:0]  mul_p
);

    localparam int unsigned OP_W   = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned ACC_W  = 16;
    localparam int unsigned STEP_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STEP,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d, step_nxt_c;
    logic [OP_W-1:0]     a_q, a_d, b_q, b_d;
    logic [ACC_W-1:0]    acc_q, acc_d, partial_c;
    logic [NIB_W-1:0]    mul_m_d, mul_q_d;
    logic                in_ready_d, out_valid_d;

    function automatic logic [NIB_W-1:0] nibble(input logic [OP_W-1:0] v, input logic hi);
        return hi ? v[7:4] : v[3:0];
    endfunction

    // Weight of the current partial product: s0 -> 0, s1/s2 -> 4, s3 -> 8.
    always_comb begin
        partial_c = ACC_W'(mul_p);
        unique case (step_q)
            2'd0:       partial_c = ACC_W'(mul_p);
            2'd1, 2'd2: partial_c = ACC_W'(mul_p) << 4;
            default:    partial_c = ACC_W'(mul_p) << 8;
        endcase
    end

    // Next-state logic; multiplier nibbles are registered one cycle ahead so
    // they are presented during the step that consumes mul_p.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        mul_m_d    = '0;
        mul_q_d    = '0;
        step_nxt_c = step_q + STEP_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d    = a;
                    b_d    = b;
                    acc_d  = '0;
                    step_d = '0;
                    if (SKIP_ZERO && (a == '0 || b == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_STEP;
                        mul_m_d = nibble(a, 1'b0);
                        mul_q_d = nibble(b, 1'b0);
                    end
                end
            end
            ST_STEP: begin
                acc_d  = acc_q + partial_c;
                step_d = step_nxt_c;
                if (step_q == STEP_W'(3)) begin
                    state_d = ST_DONE;
                end else begin
                    mul_m_d = nibble(a_q, step_nxt_c[0]);
                    mul_q_d = nibble(b_q, step_nxt_c[1]);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            mul_m     <= '0;
            mul_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            mul_m     <= mul_m_d;
            mul_q     <= mul_q_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    assign product = acc_q;

endmodule
